// File: rtl/cartesian_mul_pipe.sv
// F x I multiplier array with a LAT-stage elastic valid/ready pipeline.
// It runs in SPARSE (Cartesian) or DENSE (broadcast weight) mode per transaction and counts delivered lanes.
`timescale 1ns/1ps
module cartesian_mul_pipe #(
  parameter int unsigned F      = 4,
  parameter int unsigned I      = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned PW     = 32,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mode,
  input  logic [F*I*DW-1:0] act_data,
  input  logic [F*I-1:0]    act_vld,
  input  logic [F*DW-1:0]   wgt_data,
  input  logic [F-1:0]      wgt_vld,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [F*I*PW-1:0] out_data,
  output logic [F*I-1:0]    out_lane_vld,
  output logic              out_mode,
  input  logic              cnt_clr,
  output logic [31:0]       valid_cnt
);
  localparam int unsigned N  = F * I;
  localparam int unsigned CW = $clog2(N + 1);

  logic [LAT-1:0]  v_q;
  logic [LAT-1:0]  mode_q;
  logic [N*PW-1:0] data_q [LAT];
  logic [N-1:0]    lvld_q [LAT];
  logic [LAT-1:0]  adv_c;
  logic [N*PW-1:0] prod_c;
  logic [N-1:0]    pvld_c;
  logic [CW-1:0]   pop_c;
  logic [32:0]     sum_c;
  logic            out_xfer_c;

  // Full-precision product, sign- or zero-extended to PW
  function automatic logic [PW-1:0] mul_ext(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic signed [2*DW-1:0] sp;
    logic [2*DW-1:0]        up;
    sp = (2*DW)'($signed(a)) * (2*DW)'($signed(b));
    up = (2*DW)'(a) * (2*DW)'(b);
    if (SIGNED) return PW'(sp);
    else        return PW'(up);
  endfunction

  // A stage advances when it, or any stage downstream of it, has a hole, or the sink is ready
  always_comb begin
    logic hole;
    adv_c = '0;
    hole  = 1'b0;
    for (int s = int'(LAT) - 1; s >= 0; s--) begin
      hole     = hole | !v_q[s];
      adv_c[s] = hole | out_ready;
    end
  end

  assign in_ready = adv_c[0];

  always_comb begin
    prod_c = '0;
    pvld_c = '0;
    for (int f = 0; f < int'(F); f++) begin
      for (int i = 0; i < int'(I); i++) begin
        if (mode) begin
          pvld_c[f*I+i] = wgt_vld[f] & act_vld[i];
          prod_c[(f*I+i)*PW +: PW] = mul_ext(act_data[i*DW +: DW], wgt_data[f*DW +: DW]);
        end else begin
          pvld_c[f*I+i] = act_vld[f*I+i] & wgt_vld[0];
          prod_c[(f*I+i)*PW +: PW] = mul_ext(act_data[(f*I+i)*DW +: DW], wgt_data[0 +: DW]);
        end
        if (!pvld_c[f*I+i]) prod_c[(f*I+i)*PW +: PW] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= '0;
      mode_q <= '0;
      for (int s = 0; s < int'(LAT); s++) begin
        data_q[s] <= '0;
        lvld_q[s] <= '0;
      end
    end else begin
      if (adv_c[0]) begin
        v_q[0] <= in_valid;
        if (in_valid) begin
          data_q[0] <= prod_c;
          lvld_q[0] <= pvld_c;
          mode_q[0] <= mode;
        end
      end
      for (int s = 1; s < int'(LAT); s++) begin
        if (adv_c[s]) begin
          v_q[s] <= v_q[s-1];
          if (v_q[s-1]) begin
            data_q[s] <= data_q[s-1];
            lvld_q[s] <= lvld_q[s-1];
            mode_q[s] <= mode_q[s-1];
          end
        end
      end
    end
  end

  assign out_valid    = v_q[LAT-1];
  assign out_data     = data_q[LAT-1];
  assign out_lane_vld = lvld_q[LAT-1];
  assign out_mode     = mode_q[LAT-1];
  assign out_xfer_c   = out_valid & out_ready;

  always_comb begin
    pop_c = '0;
    for (int k = 0; k < int'(N); k++) pop_c = pop_c + CW'(out_lane_vld[k]);
  end

  assign sum_c = 33'(valid_cnt) + 33'(pop_c);

  // Saturating delivered-lane counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (!rst)            valid_cnt <= '0;
    else if (cnt_clr)    valid_cnt <= '0;
    else if (out_xfer_c) valid_cnt <= sum_c[32] ? 32'hFFFF_FFFF : sum_c[31:0];
  end
endmodule
